// File: rtl/pll_reconfig_seq_pkg.sv
// Shared types and constants for the PAL/NTSC PLL retune sequencer.
package pll_reconfig_pkg;

    typedef enum logic [2:0] {
        IDLE, W_MODE, W_M, W_K, W_C0, W_START, POLL, WAIT_LOCK
    } state_t;

    localparam logic [5:0] ADDR_MODE   = 6'd0;
    localparam logic [5:0] ADDR_STATUS = 6'd1;
    localparam logic [5:0] ADDR_START  = 6'd2;
    localparam logic [5:0] ADDR_M      = 6'd4;
    localparam logic [5:0] ADDR_C      = 6'd5;
    localparam logic [5:0] ADDR_K      = 6'd7;

    localparam logic [31:0] PAL_M   = 32'h0000_0404;
    localparam logic [31:0] PAL_K   = 32'd2201370713;
    localparam logic [31:0] PAL_C0  = 32'h0000_0606;
    localparam logic [31:0] NTSC_M  = 32'h0002_0403;
    localparam logic [31:0] NTSC_K  = 32'd3670244030;
    localparam logic [31:0] NTSC_C0 = 32'h0000_0606;

    // Counter select field (bits 22:18) of the C write; C0 is counter 0.
    localparam logic [4:0] C0_CNT_SEL = 5'd0;

    localparam int LOCK_TIMEOUT_DEF = 2_000_000;
    localparam int TMO_W            = 21;

    typedef struct packed {
        logic [31:0] m;
        logic [31:0] k;
        logic [31:0] c0;
    } cfg_set_t;

    function automatic cfg_set_t cfg_for(input logic ntsc);
        cfg_set_t s;
        if (ntsc) s = '{m: NTSC_M, k: NTSC_K, c0: NTSC_C0};
        else      s = '{m: PAL_M,  k: PAL_K,  c0: PAL_C0};
        return s;
    endfunction

endpackage

// File: rtl/pll_reconfig_seq_mgmt_beat.sv
// One-transaction Avalon-MM master: holds a read or write until the slave
// drops waitrequest; a new beat may be loaded on the accepting edge.
module mgmt_beat (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        go,
    input  logic        rnw,
    input  logic [5:0]  addr,
    input  logic [31:0] data,
    output logic        ack,
    output logic [31:0] rdata,
    output logic [5:0]  mgmt_address,
    output logic        mgmt_write,
    output logic        mgmt_read,
    output logic [31:0] mgmt_writedata,
    input  logic [31:0] mgmt_readdata,
    input  logic        mgmt_waitrequest
);

    logic active;

    assign active = mgmt_write | mgmt_read;
    assign ack    = active & ~mgmt_waitrequest;
    assign rdata  = mgmt_readdata;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            mgmt_write     <= 1'b0;
            mgmt_read      <= 1'b0;
            mgmt_address   <= '0;
            mgmt_writedata <= '0;
        end else if (go && (!active || ack)) begin
            mgmt_write     <= ~rnw;
            mgmt_read      <= rnw;
            mgmt_address   <= addr;
            mgmt_writedata <= rnw ? 32'd0 : data;
        end else if (ack) begin
            mgmt_write <= 1'b0;
            mgmt_read  <= 1'b0;
        end
    end

endmodule

// File: rtl/pll_reconfig_seq.sv
// Retunes the system PLL between PAL and NTSC through the reconfig controller,
// then waits for re-lock (with timeout) before reporting completion.
module pll_reconfig_seq
    import pll_reconfig_pkg::*;
#(
    parameter int LOCK_TIMEOUT = LOCK_TIMEOUT_DEF
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        sel_ntsc,
    input  logic        pll_locked,
    output logic [5:0]  mgmt_address,
    output logic        mgmt_write,
    output logic        mgmt_read,
    output logic [31:0] mgmt_writedata,
    input  logic [31:0] mgmt_readdata,
    input  logic        mgmt_waitrequest,
    output logic        cfg_busy,
    output logic        cfg_done,
    output logic        cfg_error,
    output logic        cur_ntsc
);

    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(LOCK_TIMEOUT - 1);

    state_t           state, state_n;
    logic             target, init_req, blocked, err_tgt;
    logic [TMO_W-1:0] tmo_cnt;
    cfg_set_t         cfg;

    logic             go, rnw, ack;
    logic [5:0]       addr;
    logic [31:0]      data, rdata;
    logic             trigger, done_n, err_set;
    logic             rdata_unused;

    assign cfg          = cfg_for(target);
    assign rdata_unused = &{1'b0, rdata[31:1]};

    // A failed target is not retried until sel_ntsc moves away from it.
    assign trigger = pll_locked && (init_req || sel_ntsc != cur_ntsc) &&
                     !(blocked && sel_ntsc == err_tgt);

    mgmt_beat u_beat (
        .clk_sys          (clk_sys),
        .reset            (reset),
        .go               (go),
        .rnw              (rnw),
        .addr             (addr),
        .data             (data),
        .ack              (ack),
        .rdata            (rdata),
        .mgmt_address     (mgmt_address),
        .mgmt_write       (mgmt_write),
        .mgmt_read        (mgmt_read),
        .mgmt_writedata   (mgmt_writedata),
        .mgmt_readdata    (mgmt_readdata),
        .mgmt_waitrequest (mgmt_waitrequest)
    );

    // Each state issues the next beat on the edge its own beat is accepted,
    // so beats run back-to-back when the slave never stalls.
    always_comb begin
        state_n = state;
        go      = 1'b0;
        rnw     = 1'b0;
        addr    = ADDR_MODE;
        data    = '0;
        done_n  = 1'b0;
        err_set = 1'b0;
        unique case (state)
            IDLE: if (trigger) begin
                state_n = W_MODE;
                go      = 1'b1;
            end
            W_MODE: if (ack) begin
                state_n = W_M;
                go      = 1'b1;
                addr    = ADDR_M;
                data    = cfg.m;
            end
            W_M: if (ack) begin
                state_n = W_K;
                go      = 1'b1;
                addr    = ADDR_K;
                data    = cfg.k;
            end
            W_K: if (ack) begin
                state_n = W_C0;
                go      = 1'b1;
                addr    = ADDR_C;
                data    = cfg.c0 | {9'd0, C0_CNT_SEL, 18'd0};
            end
            W_C0: if (ack) begin
                state_n = W_START;
                go      = 1'b1;
                addr    = ADDR_START;
            end
            W_START: if (ack) begin
                state_n = POLL;
                go      = 1'b1;
                rnw     = 1'b1;
                addr    = ADDR_STATUS;
            end
            POLL: if (ack) begin
                if (rdata[0]) begin
                    state_n = WAIT_LOCK;
                end else begin
                    go   = 1'b1;
                    rnw  = 1'b1;
                    addr = ADDR_STATUS;
                end
            end
            WAIT_LOCK: begin
                if (pll_locked) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                end else if (tmo_cnt == TMO_LAST) begin
                    state_n = IDLE;
                    err_set = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state     <= IDLE;
            target    <= 1'b0;
            init_req  <= 1'b1;
            blocked   <= 1'b0;
            err_tgt   <= 1'b0;
            tmo_cnt   <= '0;
            cfg_busy  <= 1'b0;
            cfg_done  <= 1'b0;
            cfg_error <= 1'b0;
            cur_ntsc  <= 1'b0;
        end else begin
            state    <= state_n;
            cfg_busy <= (state_n != IDLE);
            cfg_done <= done_n;
            if (state == IDLE && trigger) begin
                target   <= sel_ntsc;
                init_req <= 1'b0;
            end
            if (done_n) cur_ntsc <= target;
            if (err_set) begin
                cfg_error <= 1'b1;
                blocked   <= 1'b1;
                err_tgt   <= target;
            end else if (blocked && sel_ntsc != err_tgt) begin
                blocked <= 1'b0;
            end
            // Held at zero outside WAIT_LOCK, so it starts from zero on entry.
            if (state != WAIT_LOCK)  tmo_cnt <= '0;
            else if (tmo_cnt != '1) tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_pll_reconfig_seq.sv
// Randomized bench: a behavioural slave/PLL plus a transaction-level model of
// the expected beat list per retune, compared against a bus monitor.
module tb_pll_reconfig_seq;

    logic        clk_sys = 1'b0;
    logic        reset = 1'b1, sel_ntsc = 1'b0, pll_locked = 1'b0;
    logic [5:0]  mgmt_address;
    logic        mgmt_write, mgmt_read;
    logic [31:0] mgmt_writedata;
    logic [31:0] mgmt_readdata = '0;
    logic        mgmt_waitrequest = 1'b0;
    logic        cfg_busy, cfg_done, cfg_error, cur_ntsc;

    always #5 clk_sys = ~clk_sys;

    pll_reconfig_seq #(.LOCK_TIMEOUT(16)) dut (
        .clk_sys          (clk_sys),
        .reset            (reset),
        .sel_ntsc         (sel_ntsc),
        .pll_locked       (pll_locked),
        .mgmt_address     (mgmt_address),
        .mgmt_write       (mgmt_write),
        .mgmt_read        (mgmt_read),
        .mgmt_writedata   (mgmt_writedata),
        .mgmt_readdata    (mgmt_readdata),
        .mgmt_waitrequest (mgmt_waitrequest),
        .cfg_busy         (cfg_busy),
        .cfg_done         (cfg_done),
        .cfg_error        (cfg_error),
        .cur_ntsc         (cur_ntsc)
    );

    int checks = 0, errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Monitor state (written only by the monitor).
    logic [38:0] obs_q[$];
    int          polls_done = 0, done_cnt = 0, k_cycles = 0;
    logic        prev_stall = 1'b0, prev_done = 1'b0;
    logic [39:0] prev_vec = '0;

    // Stimulus/model state (written only by the main process).
    logic [38:0] exp_q[$];
    int          obs_base = 0, poll_base = 0, poll_zeros = 0;
    int          lock_lw = 0, lock_left = -1, kstall = 0;
    bit          lock_arm = 0, wr_rand = 0;
    bit          model_cur = 0;

    always @(negedge clk_sys) begin
        chk("rw_excl", 64'(mgmt_write & mgmt_read), 64'd0);
        if (prev_stall && !reset)
            chk("hold", {mgmt_write, mgmt_read, mgmt_address, mgmt_writedata}, prev_vec);
        prev_stall <= (mgmt_write | mgmt_read) & mgmt_waitrequest;
        prev_vec   <= {mgmt_write, mgmt_read, mgmt_address, mgmt_writedata};
        if ((mgmt_write | mgmt_read) && !mgmt_waitrequest && !reset) begin
            obs_q.push_back({mgmt_read, mgmt_address, mgmt_read ? 32'd0 : mgmt_writedata});
            if (mgmt_read) polls_done <= polls_done + 1;
        end
        if (mgmt_write && mgmt_address == 6'd7) k_cycles <= k_cycles + 1;
        if (cfg_done) begin
            done_cnt <= done_cnt + 1;
            chk("done_pulse", 64'(prev_done), 64'd0);
        end
        prev_done <= cfg_done;
    end

    // One clock; afterwards play the slave and PLL for the coming cycle.
    task automatic tick();
        @(posedge clk_sys);
        #1;
        if (lock_arm && (polls_done - poll_base) > poll_zeros) begin
            lock_arm  = 0;
            lock_left = lock_lw;
        end
        if (lock_left != 0) begin
            pll_locked = 1'b0;
            if (lock_left > 0) lock_left--;
        end else begin
            pll_locked = 1'b1;
        end
        if (kstall > 0 && mgmt_write && mgmt_address == 6'd7) begin
            mgmt_waitrequest = 1'b1;
            kstall--;
        end else begin
            mgmt_waitrequest = wr_rand ? ($urandom_range(0, 2) == 0) : 1'b0;
        end
        mgmt_readdata = {31'd0, (polls_done - poll_base) >= poll_zeros};
    endtask

    task automatic exp_seq(input bit t, input int zeros);
        exp_q.push_back({1'b0, 6'd0, 32'd0});
        exp_q.push_back({1'b0, 6'd4, t ? 32'h0002_0403 : 32'h0000_0404});
        exp_q.push_back({1'b0, 6'd7, t ? 32'd3670244030 : 32'd2201370713});
        exp_q.push_back({1'b0, 6'd5, 32'h0000_0606});
        exp_q.push_back({1'b0, 6'd2, 32'd0});
        for (int i = 0; i <= zeros; i++) exp_q.push_back({1'b1, 6'd1, 32'd0});
    endtask

    task automatic cmp_beats(input string tag);
        chk({tag, "_nbeats"}, obs_q.size() - obs_base, exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            if (obs_base + i < obs_q.size())
                chk($sformatf("%s_beat%0d", tag, i), obs_q[obs_base + i], exp_q[i]);
        exp_q.delete();
    endtask

    // Request target t; lw = cycles the PLL stays unlocked in WAIT_LOCK (-1: never locks).
    task automatic run_cfg(input string tag, input bit t, input int zeros, input int lw,
                           input bit ok, input bit exp_err, input bit exp_cur, input bit lat_chk);
        int n = 0;
        bit seen = 0;
        int d0;
        obs_base   = obs_q.size();
        poll_base  = polls_done;
        d0         = done_cnt;
        poll_zeros = zeros;
        lock_lw    = lw;
        lock_arm   = 1;
        lock_left  = 0;
        pll_locked = 1'b1;
        sel_ntsc   = t;
        exp_seq(t, zeros);
        while (n < 400) begin
            tick();
            n++;
            if (cfg_busy && !seen) begin
                seen = 1;
                chk({tag, "_first_beat"}, 64'(mgmt_write && mgmt_address == 6'd0), 64'd1);
            end else if (seen && !cfg_busy) begin
                break;
            end
        end
        chk({tag, "_end"}, 64'(seen && !cfg_busy), 64'd1);
        if (lat_chk) chk({tag, "_lat"}, n, ok ? 8 + zeros + lw : 8 + zeros + 15);
        chk({tag, "_done"}, cfg_done, ok);
        chk({tag, "_err"}, cfg_error, exp_err);
        chk({tag, "_cur"}, cur_ntsc, exp_cur);
        tick();
        chk({tag, "_ndone"}, done_cnt - d0, ok);
        cmp_beats(tag);
    endtask

    initial begin
        int  n, gap, dseen, d0, kb;
        bit  t, any_busy, found;

        // Reset with PLL unlocked: everything quiet, no start without lock.
        reset = 1'b1;
        repeat (3) tick();
        chk("rst_out", {mgmt_write, mgmt_read, mgmt_address, mgmt_writedata,
                        cfg_busy, cfg_done, cfg_error, cur_ntsc}, 64'd0);
        reset = 1'b0;
        repeat (4) tick();
        chk("no_lock_idle", 64'(cfg_busy | mgmt_write), 64'd0);

        run_cfg("init", 0, 0, 0, 1, 0, 0, 1);
        run_cfg("ntsc", 1, 0, 0, 1, 0, 1, 1);
        run_cfg("pal_poll3", 0, 2, 0, 1, 0, 0, 1);

        kstall = 3;
        kb = k_cycles;
        run_cfg("kstall", 1, 0, 0, 1, 0, 1, 0);
        chk("k_hold_cycles", k_cycles - kb, 4);
        model_cur = 1;

        wr_rand = 1;
        for (int i = 0; i < 6; i++) begin
            t = ~model_cur;
            run_cfg($sformatf("rnd%0d", i), t, $urandom_range(0, 3), $urandom_range(0, 6),
                    1, 0, t, 0);
            model_cur = t;
        end
        wr_rand = 0;

        // Lock timeout: error, no done, standard unchanged, no automatic retry.
        t = ~model_cur;
        run_cfg("tmo", t, 0, -1, 0, 1, model_cur, 1);
        lock_left = 0;
        any_busy  = 0;
        repeat (20) begin tick(); any_busy |= cfg_busy; end
        chk("tmo_no_retrig", 64'(any_busy), 64'd0);
        sel_ntsc = ~t;
        repeat (3) begin tick(); any_busy |= cfg_busy; end
        chk("tmo_same_idle", 64'(any_busy), 64'd0);
        run_cfg("after_tmo", t, 0, 0, 1, 1, t, 1);
        model_cur = t;

        // Flip the request back during W_M: finish the first set, rerun at once.
        obs_base   = obs_q.size();
        poll_base  = polls_done;
        poll_zeros = 0;
        lock_arm   = 0;
        lock_left  = 0;
        d0         = done_cnt;
        t          = ~model_cur;
        sel_ntsc   = t;
        exp_seq(t, 0);
        exp_seq(model_cur, 0);
        n = 0;
        while (n < 100 && !(mgmt_write && mgmt_address == 6'd4)) begin tick(); n++; end
        chk("wait_wm", 64'(mgmt_write && mgmt_address == 6'd4), 64'd1);
        sel_ntsc = model_cur;
        n = 0; gap = 0; dseen = 0;
        while (n < 200 && dseen < 2) begin
            tick();
            n++;
            if (dseen == 1 && !cfg_busy && !cfg_done) gap++;
            if (cfg_done) dseen++;
        end
        chk("toggle_dones", dseen, 2);
        chk("toggle_gap", gap, 0);
        chk("toggle_cur", cur_ntsc, model_cur);
        tick();
        chk("toggle_ndone", done_cnt - d0, 2);
        cmp_beats("toggle");

        // Reset in the middle of W_K.
        sel_ntsc = ~model_cur;
        n = 0;
        found = 0;
        while (n < 100 && !found) begin
            tick();
            n++;
            found = mgmt_write && mgmt_address == 6'd7;
        end
        chk("wait_wk", 64'(found), 64'd1);
        reset = 1'b1;
        tick();
        chk("rst_mid", {mgmt_write, mgmt_read, mgmt_address, mgmt_writedata,
                        cfg_busy, cfg_done, cfg_error, cur_ntsc}, 64'd0);
        reset = 1'b0;
        run_cfg("reinit", 0, 0, 0, 1, 0, 0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
